// File: rtl/fpga_ccff_pkg.sv
// rtl/fpga_ccff_pkg.sv - shared types for the ccff chain loader
// Purpose: FSM state encoding and chain-length limit for the loader.
// Ports: none (package).
package fpga_ccff_pkg;

    localparam int CCFF_CHAIN_LEN_MAX = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        VERIFY,
        FIN
    } ccff_state_t;

endpackage

// File: rtl/ccff_shadow_reg.sv
// rtl/ccff_shadow_reg.sv - indexed shadow copy of the bits loaded into the chain
// Purpose: remembers each accepted config bit by position so the recirculated
//          chain output can be compared against it.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr_en            write wr_data at wr_idx
//   wr_idx, wr_data  write position / bit
//   rd_idx, rd_data  combinational read position / bit
module ccff_shadow_reg #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_data
);

    logic [DEPTH-1:0] mem;

    // Decode by comparison so an index wider than the array never selects out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial loader and verifier for a ccff configuration chain
// Purpose: accepts CHAIN_LEN config bits over a valid/ready handshake, shifts them
//          into the chain, then recirculates the chain once to check every bit.
// Ports:
//   prog_clk, prog_reset   clock, asynchronous active-high reset
//   start                  begin a session (IDLE only)
//   bit_valid, bit_data    offered config bit
//   bit_ready              loader accepts bit_data this cycle
//   ccff_head              serial data into the chain
//   chain_clk_en           chain shifts on the next prog_clk edge
//   ccff_tail              serial data out of the chain
//   busy, done, err        session active, end-of-session pulse, sticky verify mismatch
module ccff_chain_loader
    import fpga_ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic prog_clk,
    input  logic prog_reset,
    input  logic start,
    input  logic bit_valid,
    input  logic bit_data,
    output logic bit_ready,
    output logic ccff_head,
    output logic chain_clk_en,
    input  logic ccff_tail,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    ccff_state_t      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             head_q;
    logic             en_q;
    logic             err_q;
    logic             accept;
    logic             last;
    logic             shadow_bit;

    assign accept = bit_valid & bit_ready;
    assign last   = (cnt == LAST_IDX);

    ccff_shadow_reg #(
        .DEPTH (CHAIN_LEN),
        .IDX_W (CNT_W)
    ) u_shadow (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .wr_en   (accept),
        .wr_idx  (cnt),
        .wr_data (bit_data),
        .rd_idx  (cnt),
        .rd_data (shadow_bit)
    );

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)           state_next = LOAD;
            LOAD:    if (accept && last)  state_next = DRAIN;
            DRAIN:                        state_next = VERIFY;
            VERIFY:  if (last)            state_next = FIN;
            FIN:                          state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_ready    = (state == LOAD);
        busy         = (state != IDLE);
        done         = (state == FIN);
        chain_clk_en = en_q;
        err          = err_q;
        // Recirculation: the tail feeds straight back into the head while verifying.
        ccff_head    = (state == VERIFY) ? ccff_tail : head_q;
    end

    // Shift enable is registered: an accepted bit sits in head_q for one cycle and
    // shifts on the following edge, so the last load shift lands in DRAIN.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            cnt    <= '0;
            head_q <= 1'b0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            en_q <= ((state == LOAD) && accept) || (state_next == VERIFY);
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        head_q <= bit_data;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    cnt <= '0;
                end
                VERIFY: begin
                    if (ccff_tail != shadow_bit) begin
                        err_q <= 1'b1;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
